// File: rtl/snn_fifo_pkg.sv
// Shared types and helpers for the SNN debug FIFO serializer.
package snn_fifo_pkg;

    // Widest lane configuration the serializer is built for.
    localparam int MAX_LANES = 8;

    // Serializer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAD  = 2'd1,
        ST_DATA = 2'd2
    } ser_state_e;

    // Number of serial beats needed to move one word across all lanes.
    function automatic int beats_per_word(input int data_width, input int lanes);
        return (lanes > 0) ? (data_width / lanes) : 0;
    endfunction

    // Pointer width for a power-of-two FIFO depth.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/snn_lane_serializer.sv
// Multi-lane serializer: snapshots a word at launch and shifts it out
// MSB-first on every lane, optionally preceded by zero padding beats.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no frame in flight, outputs zero
// ST_PAD  | sending PADDING zero beats (ser_valid high)
// ST_DATA | sending B data beats from the shift register
module snn_lane_serializer
    import snn_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1,
    parameter int PADDING    = 0
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_word,
    output logic                  o_busy,
    output logic                  o_last,
    output logic [LANES-1:0]      o_ser_data,
    output logic                  o_ser_valid,
    output logic                  o_ser_sof,
    output logic                  o_ser_eof
);

    localparam int B       = beats_per_word(DATA_WIDTH, LANES);
    localparam int CNT_MAX = (PADDING > B) ? PADDING : B;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] B_LAST   = CW'(B - 1);
    localparam logic [CW-1:0] PAD_LAST = CW'((PADDING > 0) ? (PADDING - 1) : 0);

    // A new frame starts in PAD when padding is configured, otherwise in DATA.
    localparam ser_state_e    LAUNCH_ST  = (PADDING > 0) ? ST_PAD : ST_DATA;
    localparam logic [CW-1:0] LAUNCH_CNT = (PADDING > 0) ? PAD_LAST : B_LAST;

    ser_state_e            r_state;
    ser_state_e            w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic                  w_in_data;

    // Each lane slice shifts left independently; its LSB refills with zero.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (B > 1) begin : g_multi
            assign w_shifted[k*B +: B] = {r_shift[k*B +: B-1], 1'b0};
        end else begin : g_single
            assign w_shifted[k*B] = 1'b0;
        end
        assign o_ser_data[k] = w_in_data & r_shift[k*B + B - 1];
    end

    assign w_in_data = (r_state == ST_DATA);

    // State, beat down-counter and shift register.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state, counter and handshake/framing outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        o_busy      = (r_state != ST_IDLE);
        o_last      = (r_state == ST_DATA) && (r_cnt == '0);
        o_ser_valid = (r_state != ST_IDLE);
        o_ser_eof   = (r_state == ST_DATA) && (r_cnt == '0);
        if (PADDING > 0) begin
            o_ser_sof = (r_state == ST_PAD) && (r_cnt == PAD_LAST);
        end else begin
            o_ser_sof = (r_state == ST_DATA) && (r_cnt == B_LAST);
        end

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = LAUNCH_ST;
                    w_cnt_nxt   = LAUNCH_CNT;
                    w_shift_nxt = i_word;
                end
            end
            ST_PAD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = B_LAST;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_DATA: begin
                if (r_cnt == '0) begin
                    // Back-to-back launch lets the next sof follow eof directly.
                    if (i_start) begin
                        w_state_nxt = LAUNCH_ST;
                        w_cnt_nxt   = LAUNCH_CNT;
                        w_shift_nxt = i_word;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_shift_nxt = '0;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt - CW'(1);
                    w_shift_nxt = w_shifted;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_shift_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/snn_fifo_serializer_mc.sv
// SNN debug FIFO with multi-lane serial drain, full-policy selection and
// sticky loss accounting. The serializer snapshots each word at launch, so
// overwrites in the memory never disturb a frame in flight.
module snn_fifo_serializer_mc
    import snn_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int LANES      = 1,
    parameter int PADDING    = 0,
    parameter int OVERWRITE  = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic                     err_clr,
    output logic [DATA_WIDTH-1:0]    par_data,
    output logic [LANES-1:0]         ser_data,
    output logic                     ser_valid,
    output logic                     ser_sof,
    output logic                     ser_eof,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_WIDTH-1:0]     drop_cnt
);

    localparam int PW  = ptr_w(DEPTH);
    localparam int LW  = PW + 1;
    localparam bit OVR = (OVERWRITE != 0);

    if ((LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) || (LANES > MAX_LANES) ||
        (DATA_WIDTH < 1) || (beats_per_word(DATA_WIDTH, LANES) * LANES != DATA_WIDTH) ||
        (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (PADDING < 0) ||
        (OVERWRITE != 0 && OVERWRITE != 1) || (CNT_WIDTH < 1)) begin : g_illegal
        $fatal(1, "snn_fifo_serializer_mc: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_overflow;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;
    logic [DATA_WIDTH-1:0] r_par_data;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_loss;
    logic                  w_store;
    logic                  w_rd_adv;
    logic                  w_busy;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_head  = r_mem[r_rd_ptr];

    // Launch only from idle or on the final data beat; empty is registered,
    // so a word needs one cycle in the memory before it can leave.
    assign w_pop    = rd_en && !w_empty && (!w_busy || w_last);
    assign w_loss   = wr_en && w_full && !w_pop;
    assign w_store  = wr_en && (!w_full || w_pop || OVR);
    // Overwriting on full discards the oldest entry by skipping the head.
    assign w_rd_adv = w_pop || (w_loss && OVR);

    // FIFO storage; occupancy gates every read so no reset is required.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_store && !w_rd_adv) begin
                r_level <= r_level + LW'(1);
            end else if (w_rd_adv && !w_store) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    // Sticky loss flag and saturating drop counter; a loss beats a clear.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_loss) begin
            r_overflow <= 1'b1;
            if (err_clr) begin
                r_drop_cnt <= CNT_WIDTH'(1);
            end else if (r_drop_cnt != {CNT_WIDTH{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
            end
        end else if (err_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    // Parallel copy of the word most recently launched.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_par_data <= '0;
        end else if (w_pop) begin
            r_par_data <= w_head;
        end
    end

    snn_lane_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .PADDING    (PADDING)
    ) u_ser (
        .clk         (clk),
        .rst_i       (rst_i),
        .i_start     (w_pop),
        .i_word      (w_head),
        .o_busy      (w_busy),
        .o_last      (w_last),
        .o_ser_data  (ser_data),
        .o_ser_valid (ser_valid),
        .o_ser_sof   (ser_sof),
        .o_ser_eof   (ser_eof)
    );

    assign par_data = r_par_data;
    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule
